// File: rtl/pipelined_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and a
// constant-evaluable clog2 helper used to size the shift-amount field.
// Purely declarative; no logic, no latency, no flow control.
package pipelined_shifter_pkg;

   localparam logic [1:0] SH_OP_SLL = 2'b00;
   localparam logic [1:0] SH_OP_SRL = 2'b01;
   localparam logic [1:0] SH_OP_SRA = 2'b10;
   localparam logic [1:0] SH_OP_ROR = 2'b11;

   // Smallest r with 2^r >= value; usable in parameter expressions.
   function automatic int sh_clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/pipelined_shifter_stage.sv
// One barrel-shifter stage: right shift by DIST when enabled, filling from the
// fill bit, or (with SHIFTER_ROTATE_EN) from the bits shifted out for rotate.
// Purely combinational: zero latency, no flow control of its own.
module pipelined_shifter_stage #(
   parameter int WIDTH = 32,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_en,
   input  logic             i_fill,
   input  logic             i_rot,
   output logic [WIDTH-1:0] o_data
);

   logic [DIST-1:0] w_fill_bits;

`ifdef SHIFTER_ROTATE_EN
   // Rotate wraps the low DIST bits back into the top of the word.
   assign w_fill_bits = i_rot ? i_data[DIST-1:0] : {DIST{i_fill}};
`else
   logic w_unused_rot;
   assign w_unused_rot = i_rot;
   assign w_fill_bits  = {DIST{i_fill}};
`endif

   assign o_data = i_en ? {w_fill_bits, i_data[WIDTH-1:DIST]} : i_data;

endmodule

// File: rtl/pipelined_shifter.sv
// Elastic pipelined SLL/SRL/SRA (+ROR under SHIFTER_ROTATE_EN) barrel shifter.
// Latency = popcount(REG_MASK with top bit forced), 1..LOG2W cycles.
// Per-slot valid/ready: a slot loads when empty or draining; in_ready=1 whenever out_ready=1.
module pipelined_shifter
   import pipelined_shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   localparam int LOG2W = sh_clog2(WIDTH),
   parameter logic [LOG2W-1:0] REG_MASK = {LOG2W{1'b1}},
   parameter int TAG_W = 5
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [LOG2W-1:0] in_shamt,
   input  logic [1:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag
);

   // The last stage is always registered so the output never glitches.
   localparam logic [LOG2W-1:0] REG_EFF = REG_MASK | {1'b1, {(LOG2W-1){1'b0}}};

   // SLL is done as reverse -> right shift -> reverse.
   logic [WIDTH-1:0] w_in_rev;
   logic [WIDTH-1:0] w_in_dat;
   logic             w_in_fill;

   for (genvar i = 0; i < WIDTH; i++) begin : g_rev_in
      assign w_in_rev[i] = in_data[WIDTH-1-i];
   end

   assign w_in_dat  = (in_op == SH_OP_SLL) ? w_in_rev : in_data;
   assign w_in_fill = (in_op == SH_OP_SRA) & in_data[WIDTH-1];

   for (genvar s = 0; s < LOG2W; s++) begin : g_stage
      localparam int DIST = 1 << (LOG2W - 1 - s);

      logic             w_vi, w_ri, w_vo, w_ro;
      logic [WIDTH-1:0] w_di, w_dc, w_do;
      logic [LOG2W-1:0] w_si, w_so;
      logic [1:0]       w_oi, w_oo;
      logic             w_fi, w_fo;
      logic [TAG_W-1:0] w_ti, w_to;
      logic             w_rot;

      if (s == 0) begin : g_src
         assign w_vi = in_valid;
         assign w_di = w_in_dat;
         assign w_si = in_shamt;
         assign w_oi = in_op;
         assign w_fi = w_in_fill;
         assign w_ti = in_tag;
      end else begin : g_link
         assign w_vi = g_stage[s-1].w_vo;
         assign w_di = g_stage[s-1].w_do;
         assign w_si = g_stage[s-1].w_so;
         assign w_oi = g_stage[s-1].w_oo;
         assign w_fi = g_stage[s-1].w_fo;
         assign w_ti = g_stage[s-1].w_to;
      end

      if (s == LOG2W - 1) begin : g_sink
         assign w_ro = out_ready;
      end else begin : g_next
         assign w_ro = g_stage[s+1].w_ri;
      end

`ifdef SHIFTER_ROTATE_EN
      assign w_rot = (w_oi == SH_OP_ROR);
`else
      assign w_rot = 1'b0;
`endif

      pipelined_shifter_stage #(.WIDTH(WIDTH), .DIST(DIST)) u_stage (
         .i_data (w_di),
         .i_en   (w_si[LOG2W-1-s]),
         .i_fill (w_fi),
         .i_rot  (w_rot),
         .o_data (w_dc)
      );

      if (REG_EFF[s]) begin : g_reg
         logic             r_vld;
         logic [WIDTH-1:0] r_dat;
         logic [LOG2W-1:0] r_sh;
         logic [1:0]       r_op;
         logic             r_fill;
         logic [TAG_W-1:0] r_tag;

         // Slot captures upstream whenever it is empty or its content moves on.
         always_ff @(posedge CLK or negedge RESETn) begin
            if (!RESETn) begin
               r_vld  <= 1'b0;
               r_dat  <= '0;
               r_sh   <= '0;
               r_op   <= '0;
               r_fill <= 1'b0;
               r_tag  <= '0;
            end else if (w_ri) begin
               r_vld  <= w_vi;
               r_dat  <= w_dc;
               r_sh   <= w_si;
               r_op   <= w_oi;
               r_fill <= w_fi;
               r_tag  <= w_ti;
            end
         end

         assign w_ri = !r_vld || w_ro;
         assign w_vo = r_vld;
         assign w_do = r_dat;
         assign w_so = r_sh;
         assign w_oo = r_op;
         assign w_fo = r_fill;
         assign w_to = r_tag;
      end else begin : g_comb
         assign w_ri = w_ro;
         assign w_vo = w_vi;
         assign w_do = w_dc;
         assign w_so = w_si;
         assign w_oo = w_oi;
         assign w_fo = w_fi;
         assign w_to = w_ti;
      end
   end

   logic [WIDTH-1:0] w_last;
   logic [WIDTH-1:0] w_last_rev;
   logic             w_unused_tail;

   assign w_last = g_stage[LOG2W-1].w_do;

   for (genvar i = 0; i < WIDTH; i++) begin : g_rev_out
      assign w_last_rev[i] = w_last[WIDTH-1-i];
   end

   // Shift amount and fill are spent once the last stage has been applied.
   assign w_unused_tail = ^{g_stage[LOG2W-1].w_so, g_stage[LOG2W-1].w_fo};

   assign in_ready  = g_stage[0].w_ri;
   assign out_valid = g_stage[LOG2W-1].w_vo;
   assign out_tag   = g_stage[LOG2W-1].w_to;
   assign out_data  = (g_stage[LOG2W-1].w_oo == SH_OP_SLL) ? w_last_rev : w_last;

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench: 32-bit fully registered shifter (L=5) plus an 8-bit L=1 build.
// Expected results are hand-computed constants; a negedge monitor matches
// every output transfer against the queue of accepted operations.
module tb_pipelined_shifter;
   import pipelined_shifter_pkg::*;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        RESETn;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data, out_data;
   logic [4:0]  in_shamt, in_tag, out_tag;
   logic [1:0]  in_op;

   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
   logic [7:0]  s_in_data, s_out_data;
   logic [2:0]  s_in_shamt;
   logic [1:0]  s_in_op;
   logic [3:0]  s_in_tag, s_out_tag;

   pipelined_shifter #(.WIDTH(32), .REG_MASK(5'b11111), .TAG_W(5)) u_dut (
      .CLK(CLK), .RESETn(RESETn),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag)
   );

   pipelined_shifter #(.WIDTH(8), .REG_MASK(3'b000), .TAG_W(4)) u_dut8 (
      .CLK(CLK), .RESETn(RESETn),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .in_shamt(s_in_shamt), .in_op(s_in_op), .in_tag(s_in_tag),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_data(s_out_data), .out_tag(s_out_tag)
   );

   int n_checks = 0;
   int n_errors = 0;
   int n_acc = 0;
   int n_out = 0;
   int cyc = 0;

   logic [36:0] exp_q[$];
   logic [36:0] mon_e;
   logic [31:0] cur_exp_dat;
   logic [4:0]  cur_exp_tag;

   task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   always @(posedge CLK) cyc++;

   // Accepts push the hand-computed expectation; output transfers pop and compare.
   always @(negedge CLK) begin
      if (RESETn && in_valid && in_ready) begin
         exp_q.push_back({cur_exp_tag, cur_exp_dat});
         n_acc++;
      end
      if (out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            check_val("stale_out", {63'b0, out_valid}, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check_val("out_data", {32'b0, out_data}, {32'b0, mon_e[31:0]});
            check_val("out_tag", {59'b0, out_tag}, {59'b0, mon_e[36:32]});
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] d,
                       input logic [4:0] tag, input logic [31:0] exp);
      bit acc;
      int w;
      in_valid = 1'b1; in_op = op; in_shamt = sh; in_data = d; in_tag = tag;
      cur_exp_dat = exp; cur_exp_tag = tag;
      acc = 1'b0; w = 0;
      while (!acc && w < 200) begin
         @(negedge CLK);
         acc = in_ready;
         @(posedge CLK);
         #1;
         w++;
      end
      check_val("send_accept", {63'b0, acc}, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 300) begin
         @(posedge CLK);
         w++;
      end
      repeat (2) @(posedge CLK);
      #1;
      check_val("drain", exp_q.size(), 64'd0);
   endtask

   task automatic send8(input logic [1:0] op, input logic [2:0] sh, input logic [7:0] d,
                        input logic [3:0] tag, input logic [7:0] exp);
      s_in_valid = 1'b1; s_in_op = op; s_in_shamt = sh; s_in_data = d; s_in_tag = tag;
      @(posedge CLK);
      #1;
      s_in_valid = 1'b0;
      @(negedge CLK);
      check_val("w8_valid", {63'b0, s_out_valid}, 64'd1);
      check_val("w8_data", {56'b0, s_out_data}, {56'b0, exp});
      check_val("w8_tag", {60'b0, s_out_tag}, {60'b0, tag});
   endtask

   int          lat;
   int          c0;
   int          base_acc;
   int          base_out;
   logic [31:0] snap;

   initial begin
      RESETn = 1'b0;
      in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0; out_ready = 1'b1;
      s_in_valid = 1'b0; s_in_data = '0; s_in_shamt = '0; s_in_op = '0; s_in_tag = '0;
      s_out_ready = 1'b1;
      cur_exp_dat = '0; cur_exp_tag = '0;

      repeat (2) @(posedge CLK);
      @(negedge CLK);
      check_val("rst_out_valid", {63'b0, out_valid}, 64'd0);
      check_val("rst_out_data", {32'b0, out_data}, 64'd0);
      check_val("rst_out_tag", {59'b0, out_tag}, 64'd0);
      check_val("rst_in_ready", {63'b0, in_ready}, 64'd1);
      check_val("rst_w8_valid", {63'b0, s_out_valid}, 64'd0);
      @(posedge CLK);
      #1 RESETn = 1'b1;
      @(posedge CLK);
      #1;

      // First op: latency of five registered stages, tag carried through.
      send(SH_OP_SRL, 5'd31, 32'h8000_0000, 5'h15, 32'h0000_0001);
      lat = 0;
      do begin
         @(negedge CLK);
         lat++;
      end while (!out_valid && lat < 20);
      check_val("latency", lat, 64'd5);
      drain();

      // Directed vectors, issued back to back.
      send(SH_OP_SRA, 5'd4,  32'h8000_0000, 5'd1,  32'hF800_0000);
      send(SH_OP_SLL, 5'd31, 32'h0000_0001, 5'd2,  32'h8000_0000);
      send(SH_OP_SRL, 5'd0,  32'hA5A5_0F0F, 5'd3,  32'hA5A5_0F0F);
      send(SH_OP_SLL, 5'd0,  32'hA5A5_0F0F, 5'd4,  32'hA5A5_0F0F);
      send(SH_OP_SRA, 5'd0,  32'hA5A5_0F0F, 5'd5,  32'hA5A5_0F0F);
      send(SH_OP_ROR, 5'd0,  32'hA5A5_0F0F, 5'd6,  32'hA5A5_0F0F);
      send(SH_OP_SRA, 5'd31, 32'h8000_0000, 5'd7,  32'hFFFF_FFFF);
      send(SH_OP_SRA, 5'd4,  32'h7FFF_FFFF, 5'd8,  32'h07FF_FFFF);
      send(SH_OP_SRL, 5'd12, 32'hDEAD_BEEF, 5'd9,  32'h000D_EADB);
      send(SH_OP_SLL, 5'd12, 32'hDEAD_BEEF, 5'd10, 32'hDBEE_F000);
      send(SH_OP_SRA, 5'd12, 32'hDEAD_BEEF, 5'd11, 32'hFFFD_EADB);
      send(SH_OP_SRL, 5'd21, 32'hDEAD_BEEF, 5'd12, 32'h0000_06F5);
      send(SH_OP_SLL, 5'd21, 32'hDEAD_BEEF, 5'd13, 32'hDDE0_0000);
`ifdef SHIFTER_ROTATE_EN
      send(SH_OP_ROR, 5'd1,  32'h0000_0001, 5'd14, 32'h8000_0000);
      send(SH_OP_ROR, 5'd8,  32'h1234_5678, 5'd15, 32'h7812_3456);
`else
      send(SH_OP_ROR, 5'd1,  32'h0000_0001, 5'd14, 32'h0000_0000);
      send(SH_OP_ROR, 5'd8,  32'h1234_5678, 5'd15, 32'h0012_3456);
`endif
      drain();

      // Sixteen ops on consecutive cycles; results must follow with no bubbles.
      c0 = cyc;
      base_out = n_out;
      for (int i = 0; i < 16; i++) begin
         if (i % 2 == 0)
            send(SH_OP_SRL, 5'(i), 32'hFFFF_FFFF, 5'(i), 32'hFFFF_FFFF >> i);
         else
            send(SH_OP_SLL, 5'(i), 32'h0000_0001, 5'(i), 32'h0000_0001 << i);
      end
      check_val("stream_in_cycles", cyc - c0, 64'd16);
      repeat (5) @(negedge CLK);
      #1;
      check_val("stream_out_no_bubble", exp_q.size(), 64'd0);
      check_val("stream_out_count", n_out - base_out, 64'd16);
      drain();

      // Back-pressure: five slots fill, input stalls, head result holds.
      base_acc = n_acc;
      base_out = n_out;
      out_ready = 1'b0;
      fork
         begin
            for (int j = 0; j < 8; j++)
               send(SH_OP_SRA, 5'(j), 32'h8000_0000, 5'(16 + j), 32'hFFFF_FFFF << (31 - j));
         end
         begin
            repeat (6) @(negedge CLK);
            #1;
            check_val("bp_head_valid", {63'b0, out_valid}, 64'd1);
            check_val("bp_head_data", {32'b0, out_data}, 64'h8000_0000);
            snap = out_data;
            repeat (4) @(negedge CLK);
            #1;
            check_val("bp_accepts", n_acc - base_acc, 64'd5);
            check_val("bp_in_ready", {63'b0, in_ready}, 64'd0);
            check_val("bp_stable_data", {32'b0, out_data}, {32'b0, snap});
            check_val("bp_stable_tag", {59'b0, out_tag}, 64'd16);
            @(posedge CLK);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check_val("bp_out_count", n_out - base_out, 64'd8);

      // Reset while three ops are in flight, one of them presented at the output.
      send(SH_OP_SRL, 5'd1, 32'h0000_0100, 5'd1, 32'h0000_0080);
      send(SH_OP_SRL, 5'd2, 32'h0000_0100, 5'd2, 32'h0000_0040);
      send(SH_OP_SRL, 5'd3, 32'h0000_0100, 5'd3, 32'h0000_0020);
      out_ready = 1'b0;
      repeat (6) @(posedge CLK);
      #1;
      check_val("rst_pre_valid", {63'b0, out_valid}, 64'd1);
      RESETn = 1'b0;
      #1;
      check_val("rst_mid_valid", {63'b0, out_valid}, 64'd0);
      check_val("rst_mid_data", {32'b0, out_data}, 64'd0);
      check_val("rst_mid_in_ready", {63'b0, in_ready}, 64'd1);
      exp_q.delete();
      base_out = n_out;
      repeat (2) @(posedge CLK);
      #3 RESETn = 1'b1;
      out_ready = 1'b1;
      repeat (10) @(posedge CLK);
      #1;
      check_val("rst_no_stale", n_out - base_out, 64'd0);
      send(SH_OP_SRL, 5'd8, 32'h0000_FFFF, 5'd3, 32'h0000_00FF);
      drain();
      check_val("rst_new_op", n_out - base_out, 64'd1);

      // 8-bit, single-register build.
      @(posedge CLK);
      #1;
      send8(SH_OP_SRA, 3'd7, 8'h80, 4'd1, 8'hFF);
      send8(SH_OP_SLL, 3'd3, 8'h01, 4'd2, 8'h08);
      send8(SH_OP_SRL, 3'd4, 8'hF0, 4'd3, 8'h0F);
      send8(SH_OP_SRA, 3'd0, 8'h96, 4'd4, 8'h96);
      send8(SH_OP_SRA, 3'd2, 8'h96, 4'd5, 8'hE5);
      send8(SH_OP_SLL, 3'd5, 8'hB5, 4'd6, 8'hA0);
`ifdef SHIFTER_ROTATE_EN
      send8(SH_OP_ROR, 3'd1, 8'h81, 4'd7, 8'hC0);
`else
      send8(SH_OP_ROR, 3'd1, 8'h81, 4'd7, 8'h40);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pipelined_shifter.md
Name: pipelined_shifter

Overview:
- Parametrised, elastic-pipelined barrel shifter for the execute stage; the successor of the fixed 32-bit combinational logical-right shifter.
- Supports SLL, SRL and SRA on WIDTH-bit data, with register insertion selectable per stage.
- valid/ready handshake on both sides; a sideband tag travels with each operation so the issue logic can match results to destinations.

Parameters:
- WIDTH, 32: data width; power of 2, 8..64. LOG2W = clog2(WIDTH).
- REG_MASK, {LOG2W{1'b1}}: bit s=1 puts a pipeline register after stage s. Bit LOG2W-1 is forced to 1, so the output is always registered.
- TAG_W, 5: sideband tag width; must be at least 1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge
- RESETn  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  shifter accepts this cycle
- in_data  in  WIDTH  operand
- in_shamt  in  LOG2W  shift amount
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Optional Feature)
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_data  out  WIDTH  shifted result
- out_tag  out  TAG_W  tag of this result

Behaviour:
- Stage s (0..LOG2W-1) shifts by 2^(LOG2W-1-s) when shamt bit (LOG2W-1-s) is set.
- Fill bit:
  - 0 for SLL and SRL.
  - Operand MSB (captured at input) for SRA.
- SLL is implemented as bit-reverse, right shift, bit-reverse.
- Pipeline latency L = popcount(effective REG_MASK), between 1 and LOG2W cycles. Each register slot carries data, remaining shamt, op, sign, tag and a valid bit.
- Elastic flow per slot k: advance_k = !v_k || advance_{k+1}; the last slot uses out_ready. in_ready = advance_0. The combinational ready chain is permitted.
- A transfer happens when valid && ready on either side. With out_ready held high, the pipeline sustains 1 op per cycle.
- If out_valid=1 and out_ready=0, then out_data and out_tag hold stable until accepted. No bubbles are inserted and no op is dropped or duplicated.
- Simultaneous accept and emit with all slots full: allowed. in_ready=1 when out_ready=1.
- shamt=0 gives out_data=in_data for every op.
- SRA with the MSB set and shamt=WIDTH-1 gives all ones.
- Reset:
  - All valid bits clear asynchronously, so out_valid=0, out_data=0, out_tag=0.
  - in_ready=1 after reset, since slots are empty.
  - Reset mid-operation discards every in-flight op. No output is produced for those ops after release.
- Data registers may also be reset to 0; only valid bits are mandatory.

Optional Feature:
- Macro SHIFTER_ROTATE_EN.
- Defined: op 11 performs rotate-right by shamt. The fill bits come from the bits shifted out, with per-stage wrap.
- Undefined: op 11 is decoded as SRL, and the rotate muxes are not synthesised.

Decomposition:
- Shared package/header holds:
  - op encodings: SH_OP_SLL=2'b00, SH_OP_SRL=2'b01, SH_OP_SRA=2'b10, SH_OP_ROR=2'b11
  - clog2 helper function
- One natural sub-module, shifter_stage: combinational single-stage right shift with parameters WIDTH and DIST.
  - Inputs: data, enable bit, fill bit, rotate select.
  - Instantiated LOG2W times by a generate loop.
  - The top level owns the registers and handshake.

Test Plan:
- WIDTH=32, REG_MASK=5'b11111:
  - SRL 0x80000000 by 31 -> 0x00000001 after 5 cycles, tag preserved.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - SLL 0x00000001 by 31 -> 0x80000000.
- Back-to-back: 16 ops on consecutive cycles with out_ready=1 -> 16 results on consecutive cycles in order; tags 0..15 match the model.
- Back-pressure: out_ready=0 for 10 cycles while in_valid=1:
  - in_ready drops after 5 accepts.
  - out_data stays stable.
  - On release, every result is delivered exactly once, in order.
- Reset mid-stream: RESETn low while 3 ops are in flight -> out_valid=0 immediately; no stale result after release. A new op 0x0000FFFF SRL 8 -> 0x000000FF.
- REG_MASK=5'b10000 (L=1) and WIDTH=8/64 sweeps: random op/shamt/data against the reference model; shamt=0 returns the input.
- With SHIFTER_ROTATE_EN: ROR 0x00000001 by 1 -> 0x80000000. Without it: the same stimulus returns 0x00000000.
